// File: rtl/axis_ascon_aead128_tag_gate.sv
// Holds Ascon-AEAD128 decrypted plaintext until the tag verdict arrives; releases authentic
// messages, discards the rest, and emits one status word per message. Optional: ASCON_TAG_GATE_STATS_EN.
module axis_ascon_aead128_tag_gate #(
  parameter int depth_aw     = 4,
  parameter bit keep_support = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tlast,
  input  logic [127:0] s_tdata,
  input  logic [15:0]  s_tkeep,
  input  logic         s_tag_tvalid,
  output logic         s_tag_tready,
  input  logic [127:0] s_tag_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [127:0] m_tdata,
  output logic [15:0]  m_tkeep,
  output logic         m_status_tvalid,
  input  logic         m_status_tready,
  output logic [1:0]   m_status_tdata
`ifdef ASCON_TAG_GATE_STATS_EN
  ,
  output logic [15:0]  pass_count,
  output logic [15:0]  fail_count
`endif
);

  localparam int DEPTH = 2 ** depth_aw;
  localparam logic [depth_aw:0] PTR_ONE = 1;

  typedef enum logic [2:0] {COLLECT, WAIT_TAG, RELEASE, DISCARD, STATUS} state_e;

  state_e              state_q, state_d;
  logic [depth_aw:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic                active_q, active_d;
  logic [1:0]          status_q, status_d;
  logic [127:0]        data_mem_q [DEPTH];
  logic                last_mem_q [DEPTH];
  logic [depth_aw-1:0] wr_idx, rd_idx;
  logic                empty, full, wr_en, tag_zero;

  assign wr_idx   = wr_ptr_q[depth_aw-1:0];
  assign rd_idx   = rd_ptr_q[depth_aw-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[depth_aw] != rd_ptr_q[depth_aw]) && (wr_idx == rd_idx);
  assign tag_zero = (s_tag_tdata == '0);

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    ovf_d           = ovf_q;
    status_d        = status_q;
    active_d        = 1'b1;
    wr_en           = 1'b0;
    s_tready        = 1'b0;
    s_tag_tready    = 1'b0;
    m_tvalid        = 1'b0;
    m_status_tvalid = 1'b0;
    case (state_q)
      COLLECT: if (active_q) begin
        s_tready = 1'b1;
        // An empty buffer with no pending beat means the tag closes an empty message.
        s_tag_tready = s_tag_tvalid && empty && !s_tvalid;
        if (s_tvalid) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (s_tlast) state_d = WAIT_TAG;
        end else if (s_tag_tvalid && empty) begin
          status_d = {1'b0, tag_zero};
          state_d  = STATUS;
        end
      end
      WAIT_TAG: begin
        s_tag_tready = 1'b1;
        if (s_tag_tvalid) begin
          status_d = {ovf_q, tag_zero && !ovf_q};
          state_d  = (tag_zero && !ovf_q) ? RELEASE : DISCARD;
        end
      end
      RELEASE: begin
        m_tvalid = !empty;
        if (m_tvalid && m_tready) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (last_mem_q[rd_idx]) state_d = STATUS;
        end
      end
      DISCARD: begin
        rd_ptr_d = wr_ptr_q;
        state_d  = STATUS;
      end
      STATUS: begin
        m_status_tvalid = 1'b1;
        if (m_status_tready) begin
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      status_q <= 2'b00;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
      active_q <= active_d;
    end
  end

  // Buffer storage carries no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem_q[wr_idx] <= s_tdata;
      last_mem_q[wr_idx] <= s_tlast;
    end
  end

  assign m_tdata        = data_mem_q[rd_idx];
  assign m_tlast        = last_mem_q[rd_idx];
  assign m_status_tdata = status_q;

  generate
    if (keep_support) begin : g_keep
      logic [15:0] keep_mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en) keep_mem_q[wr_idx] <= s_tkeep;
      end
      assign m_tkeep = keep_mem_q[rd_idx];
    end else begin : g_no_keep
      logic unused_keep;
      assign unused_keep = ^s_tkeep;
      assign m_tkeep     = 16'hFFFF;
    end
  endgenerate

`ifdef ASCON_TAG_GATE_STATS_EN
  logic [15:0] pass_q, pass_d, fail_q, fail_d;

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (m_status_tvalid && m_status_tready) begin
      if (status_q[0]) begin
        if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
      end else if (fail_q != 16'hFFFF) begin
        fail_d = fail_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass_count = pass_q;
  assign fail_count = fail_q;
`endif

endmodule

// File: tb/tb_axis_ascon_aead128_tag_gate.sv
// Bench for axis_ascon_aead128_tag_gate: message-level reference model, per-cycle compare
// process, directed pins for the documented scenarios plus randomized backpressured traffic.
module tb_axis_ascon_aead128_tag_gate;

  localparam int DEPTH_AW = 2;
  localparam int DEPTH    = 1 << DEPTH_AW;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic         clk, resetn;
  logic         s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tag_tvalid, s_tag_tready;
  logic [127:0] s_tag_tdata;
  logic         m_tvalid, m_tready, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_status_tvalid, m_status_tready;
  logic [1:0]   m_status_tdata;
`ifdef ASCON_TAG_GATE_STATS_EN
  logic [15:0]  pass_count, fail_count;
`endif

  axis_ascon_aead128_tag_gate #(.depth_aw(DEPTH_AW), .keep_support(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready), .s_tag_tdata(s_tag_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_status_tvalid(m_status_tvalid), .m_status_tready(m_status_tready),
    .m_status_tdata(m_status_tdata)
`ifdef ASCON_TAG_GATE_STATS_EN
    , .pass_count(pass_count), .fail_count(fail_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t      exp_beats [$];
  logic [1:0] exp_stat  [$];
  beat_t      rel_log   [$];
  logic [1:0] stat_log  [$];
  beat_t      cur_msg   [$];

  int cyc = 0, tag_cyc = -1, mv_rise = -1, sv_rise = -1, last_cyc = -1;
  int bp_mode = 2;
  logic man_tready = 1'b0, man_sready = 1'b0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic die(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench stopped");
  endtask

  // Sink-side ready generation: always ready, random, or manual.
  initial begin
    m_tready = 1'b0;
    m_status_tready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (bp_mode)
        0: begin m_tready = 1'b1; m_status_tready = 1'b1; end
        1: begin m_tready = 1'($urandom_range(0, 1)); m_status_tready = 1'($urandom_range(0, 1)); end
        default: begin m_tready = man_tready; m_status_tready = man_sready; end
      endcase
    end
  end

  // Compare process: every handshake against the model, stall stability, no leakage.
  logic         p_rst = 1'b0, p_mv = 1'b0, p_mr = 1'b0, p_sv = 1'b0, p_sr = 1'b0;
  logic [144:0] p_mbeat;
  logic [1:0]   p_st;
  always @(negedge clk) begin
    beat_t e;
    logic [1:0] es;
    cyc++;
    if (resetn) begin
      if (s_tag_tvalid && s_tag_tready) tag_cyc = cyc;
      if (m_tvalid && !p_mv) mv_rise = cyc;
      if (m_status_tvalid && !p_sv) sv_rise = cyc;
      if (p_rst && p_mv && !p_mr)
        check("m stall hold", 160'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 160'({1'b1, p_mbeat}));
      if (p_rst && p_sv && !p_sr)
        check("status stall hold", 160'({m_status_tvalid, m_status_tdata}), 160'({1'b1, p_st}));
      if (m_tvalid) begin
        check("tag ready during release", 160'(s_tag_tready), 160'(0));
        check("no unauthenticated beat", 160'(exp_beats.size() != 0), 160'(1));
      end
      if (m_tvalid && m_tready && exp_beats.size() != 0) begin
        e = exp_beats.pop_front();
        check("m beat", 160'({m_tdata, m_tkeep, m_tlast}), 160'(e));
        rel_log.push_back(beat_t'({m_tdata, m_tkeep, m_tlast}));
        if (m_tlast) last_cyc = cyc;
      end
      if (m_status_tvalid && m_status_tready) begin
        if (exp_stat.size() == 0) begin
          check("unexpected status", 160'(1), 160'(0));
        end else begin
          es = exp_stat.pop_front();
          check("status word", 160'(m_status_tdata), 160'(es));
        end
        stat_log.push_back(m_status_tdata);
      end
    end
    p_rst = resetn;
    p_mv = m_tvalid; p_mr = m_tready; p_mbeat = {m_tdata, m_tkeep, m_tlast};
    p_sv = m_status_tvalid; p_sr = m_status_tready; p_st = m_status_tdata;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input beat_t b);
    bit got = 1'b0;
    s_tvalid = 1'b1; s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last;
    for (int t = 0; t < 3000 && !got; t++) begin @(negedge clk); got = s_tready; end
    if (!got) die("s_tready");
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_tag(input logic [127:0] tag);
    bit got = 1'b0;
    s_tag_tvalid = 1'b1; s_tag_tdata = tag;
    for (int t = 0; t < 3000 && !got; t++) begin @(negedge clk); got = s_tag_tready; end
    if (!got) die("s_tag_tready");
    @(posedge clk); #1;
    s_tag_tvalid = 1'b0;
  endtask

  // Message-level model: what must come out follows from length, capacity and tag alone.
  task automatic run_msg(input logic [127:0] tag, input bit gaps);
    int n = cur_msg.size();
    if (n == 0) exp_stat.push_back({1'b0, tag == 0});
    else if (n > DEPTH) exp_stat.push_back(2'b10);
    else if (tag == 0) begin
      foreach (cur_msg[i]) exp_beats.push_back(cur_msg[i]);
      exp_stat.push_back(2'b01);
    end else exp_stat.push_back(2'b00);
    foreach (cur_msg[i]) begin
      if (gaps) idle($urandom_range(0, 2));
      send_beat(cur_msg[i]);
    end
    if (gaps) idle($urandom_range(0, 3));
    send_tag(tag);
  endtask

  task automatic mk_msg(input int n);
    beat_t b;
    cur_msg.delete();
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = 16'($urandom);
      b.last = (i == n - 1);
      cur_msg.push_back(b);
    end
  endtask

  task automatic mk_t1();
    cur_msg.delete();
    cur_msg.push_back('{data: 128'h1, keep: 16'hFFFF, last: 1'b0});
    cur_msg.push_back('{data: 128'h2, keep: 16'hFFFF, last: 1'b0});
    cur_msg.push_back('{data: 128'h3, keep: 16'h00FF, last: 1'b1});
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      done = (exp_beats.size() == 0) && (exp_stat.size() == 0);
    end
    if (!done) die(nm);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    rel_log.delete(); stat_log.delete();
    tag_cyc = -1; mv_rise = -1; sv_rise = -1; last_cyc = -1;
  endtask

  initial begin
    bit got;
    resetn = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tag_tvalid = 1'b1; s_tag_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset m_tvalid", 160'(m_tvalid), 160'(0));
    check("reset m_status_tvalid", 160'(m_status_tvalid), 160'(0));
    check("reset s_tready", 160'(s_tready), 160'(0));
    check("reset s_tag_tready", 160'(s_tag_tready), 160'(0));
    check("reset m_status_tdata", 160'(m_status_tdata), 160'(0));
    resetn = 1'b1; s_tag_tvalid = 1'b0;
    @(posedge clk); #1;
    check("s_tready after reset", 160'(s_tready), 160'(1));

    // Good 3-beat message.
    bp_mode = 0; clear_logs(); mk_t1(); run_msg(128'h0, 1'b0); drain("t1");
    check("t1 beat count", 160'(rel_log.size()), 160'(3));
    check("t1 b0", 160'(rel_log[0]), 160'({128'h1, 16'hFFFF, 1'b0}));
    check("t1 b1", 160'(rel_log[1]), 160'({128'h2, 16'hFFFF, 1'b0}));
    check("t1 b2", 160'(rel_log[2]), 160'({128'h3, 16'h00FF, 1'b1}));
    check("t1 status", 160'(stat_log[0]), 160'(2'b01));
    check("t1 first beat latency", 160'(mv_rise - tag_cyc), 160'(1));
    check("t1 status latency", 160'(sv_rise - last_cyc), 160'(1));

    // Same message, failing tag, then a good one.
    clear_logs(); mk_t1(); run_msg(128'h1, 1'b0); drain("t2");
    check("t2 no beats", 160'(rel_log.size()), 160'(0));
    check("t2 status", 160'(stat_log[0]), 160'(2'b00));
    check("t2 discard latency", 160'(sv_rise - tag_cyc), 160'(2));
    clear_logs(); mk_msg(2); run_msg(128'h0, 1'b0); drain("t2b");
    check("t2b beats", 160'(rel_log.size()), 160'(2));

    // Overflow: six beats into four entries.
    clear_logs(); mk_msg(6); run_msg(128'h0, 1'b0); drain("t3");
    check("t3 no beats", 160'(rel_log.size()), 160'(0));
    check("t3 status", 160'(stat_log[0]), 160'(2'b10));

    // Empty message.
    clear_logs(); cur_msg.delete(); run_msg(128'h0, 1'b0); drain("t4");
    check("t4 no beats", 160'(rel_log.size()), 160'(0));
    check("t4 status", 160'(stat_log[0]), 160'(2'b01));

    // Randomized traffic under backpressure.
    bp_mode = 1;
    for (int m = 0; m < 20; m++) begin
      mk_msg($urandom_range(0, 6));
      run_msg(($urandom_range(0, 3) == 0) ? (128'h1 << $urandom_range(0, 127)) : 128'h0, 1'b1);
    end
    drain("random");

    // Reset in the middle of a release.
    bp_mode = 2; man_tready = 1'b0; man_sready = 1'b1;
    mk_msg(4); run_msg(128'h0, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin @(negedge clk); got = m_tvalid; end
    if (!got) die("release before reset");
    @(posedge clk); #1; man_tready = 1'b1;
    @(posedge clk); #1; man_tready = 1'b0; resetn = 1'b0;
    exp_beats.delete(); exp_stat.delete();
    @(posedge clk); #1;
    check("mid reset m_tvalid", 160'(m_tvalid), 160'(0));
    check("mid reset m_status_tvalid", 160'(m_status_tvalid), 160'(0));
    check("mid reset s_tready", 160'(s_tready), 160'(0));
    check("mid reset s_tag_tready", 160'(s_tag_tready), 160'(0));
    resetn = 1'b1;
    @(posedge clk); #1;
    bp_mode = 0; clear_logs(); mk_msg(2); run_msg(128'h0, 1'b0); drain("post reset");
    check("post reset beats", 160'(rel_log.size()), 160'(2));
    check("post reset status", 160'(stat_log.size() == 1 ? stat_log[0] : 2'b11), 160'(2'b01));

    idle(5);
    check("model drained", 160'(exp_beats.size() + exp_stat.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
